// File: rtl/rv_ctrl_pkg.sv
// Shared control-word layout and opcode constants for the RV32I decoder and
// the pipeline registers downstream of it.
package rv_ctrl_pkg;

    localparam int CTRL_W = 11;

    localparam int CTRL_IMMSEL_LO = 0;
    localparam int CTRL_IMMSEL_HI = 1;
    localparam int CTRL_ALUSRC    = 2;
    localparam int CTRL_MEM2REG   = 3;
    localparam int CTRL_REGWR     = 4;
    localparam int CTRL_MEMRD     = 5;
    localparam int CTRL_MEMWR     = 6;
    localparam int CTRL_BRANCH    = 7;
    localparam int CTRL_ALUOP_LO  = 8;
    localparam int CTRL_ALUOP_HI  = 10;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;

    // rs2 is a real source unless the ALU takes the immediate; stores read it as data.
    function automatic logic rs2_used(input logic alusrc, input logic memwr);
        return ~alusrc | memwr;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side inputs and EX-side outputs of the ID/EX pipeline register.
// master drives the ID fields and observes EX; slave is the stage itself.
interface id_ex_stage_if
    import rv_ctrl_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) ();

    logic              id_valid;
    logic [CTRL_W-1:0] id_ctrl;
    logic [XLEN-1:0]   id_pc;
    logic [XLEN-1:0]   id_rs1_data;
    logic [XLEN-1:0]   id_rs2_data;
    logic [XLEN-1:0]   id_imm;
    logic [RA_W-1:0]   id_rs1;
    logic [RA_W-1:0]   id_rs2;
    logic [RA_W-1:0]   id_rd;
    logic [3:0]        id_funct;

    logic              ex_valid;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_rs1_data;
    logic [XLEN-1:0]   ex_rs2_data;
    logic [XLEN-1:0]   ex_imm;
    logic [RA_W-1:0]   ex_rs1;
    logic [RA_W-1:0]   ex_rs2;
    logic [RA_W-1:0]   ex_rd;
    logic [3:0]        ex_funct;

    modport master (
        output id_valid, id_ctrl, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_funct,
        input  ex_valid, ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_funct
    );

    modport slave (
        input  id_valid, id_ctrl, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_funct,
        output ex_valid, ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_funct
    );

endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard compare: a load sitting in EX whose destination is read
// by the instruction currently in ID.
module load_use_detect
    import rv_ctrl_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic            ex_valid,
    input  logic            ex_memrd,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            id_valid,
    input  logic            id_alusrc,
    input  logic            id_memwr,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    output logic            hazard
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = (id_rs1 == ex_rd);
    assign rs2_match = (id_rs2 == ex_rd) & rs2_used(id_alusrc, id_memwr);

    // x0 is never written, so a load into it cannot create a dependency.
    assign hazard = ex_valid & ex_memrd & (ex_rd != '0) & id_valid
                  & (rs1_match | rs2_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// memory-busy freeze (flush deferred until release) and a saturating bubble count.
module id_ex_stage
    import rv_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    id_ex_stage_if.slave     bus,
    input  logic             ex_flush,
    input  logic             mem_busy,
    output logic             stall_o,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   rs1_data_q;
    logic [XLEN-1:0]   rs2_data_q;
    logic [XLEN-1:0]   imm_q;
    logic [RA_W-1:0]   rs1_q;
    logic [RA_W-1:0]   rs2_q;
    logic [RA_W-1:0]   rd_q;
    logic [3:0]        funct_q;
    logic              pending_flush_q;
    logic [CNT_W-1:0]  cnt_q;

    logic hazard;
    logic flush_eff;

    load_use_detect #(.RA_W(RA_W)) u_load_use_detect (
        .ex_valid  (valid_q),
        .ex_memrd  (ctrl_q[CTRL_MEMRD]),
        .ex_rd     (rd_q),
        .id_valid  (bus.id_valid),
        .id_alusrc (bus.id_ctrl[CTRL_ALUSRC]),
        .id_memwr  (bus.id_ctrl[CTRL_MEMWR]),
        .id_rs1    (bus.id_rs1),
        .id_rs2    (bus.id_rs2),
        .hazard    (hazard)
    );

    assign flush_eff = ex_flush | pending_flush_q;

    // A flush overrides the hazard so IF moves on to the branch target.
    assign stall_o = mem_busy | (hazard & ~flush_eff);

    // NOTE: every register here is written with <= so all flops sample pre-edge values together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q         <= 1'b0;
            ctrl_q          <= '0;
            pc_q            <= '0;
            rs1_data_q      <= '0;
            rs2_data_q      <= '0;
            imm_q           <= '0;
            rs1_q           <= '0;
            rs2_q           <= '0;
            rd_q            <= '0;
            funct_q         <= '0;
            pending_flush_q <= 1'b0;
            cnt_q           <= '0;
        end else if (mem_busy) begin
            // Frozen: remember a flush so it takes effect on release.
            if (ex_flush) pending_flush_q <= 1'b1;
        end else if (flush_eff || hazard) begin
            valid_q         <= 1'b0;
            ctrl_q          <= '0;
            pc_q            <= '0;
            rs1_data_q      <= '0;
            rs2_data_q      <= '0;
            imm_q           <= '0;
            rs1_q           <= '0;
            rs2_q           <= '0;
            rd_q            <= '0;
            funct_q         <= '0;
            pending_flush_q <= 1'b0;
            if (!flush_eff && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
        end else begin
            valid_q    <= bus.id_valid;
            ctrl_q     <= bus.id_valid ? bus.id_ctrl : '0;
            pc_q       <= bus.id_pc;
            rs1_data_q <= bus.id_rs1_data;
            rs2_data_q <= bus.id_rs2_data;
            imm_q      <= bus.id_imm;
            rs1_q      <= bus.id_rs1;
            rs2_q      <= bus.id_rs2;
            rd_q       <= bus.id_rd;
            funct_q    <= bus.id_funct;
        end
    end

    assign bus.ex_valid    = valid_q;
    assign bus.ex_ctrl     = ctrl_q;
    assign bus.ex_pc       = pc_q;
    assign bus.ex_rs1_data = rs1_data_q;
    assign bus.ex_rs2_data = rs2_data_q;
    assign bus.ex_imm      = imm_q;
    assign bus.ex_rs1      = rs1_q;
    assign bus.ex_rs2      = rs2_q;
    assign bus.ex_rd       = rd_q;
    assign bus.ex_funct    = funct_q;
    assign bubble_cnt      = cnt_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RV32I core; sits directly downstream of the opcode decoder.
- Captures the decoder's 11-bit control word with operands and register indices, and presents them to the EX stage.
- Contains load-use hazard detection, bubble insertion, branch flush, a memory-busy hold with a deferred-flush latch, and a saturating bubble counter.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register-index width.
- CTRL_W, 11, control-word width (fixed by the decoder format).
- CNT_W, 16, bubble counter width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_ctrl  in  CTRL_W  decoder word: [1:0] imm sel, [2] AluSrc, [3] MemToReg, [4] RegWrite, [5] MemRead, [6] MemWrite, [7] Branch, [10:8] AluOp
- id_pc  in  XLEN  PC of the ID instruction
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  generated immediate
- id_rs1, id_rs2, id_rd  in  RA_W  register indices
- id_funct  in  4  {funct7[5], funct3}
- ex_flush  in  1  branch taken in EX; ID instruction must be discarded
- mem_busy  in  1  data memory not ready; the whole pipe freezes
- ex_valid  out  1
- ex_ctrl  out  CTRL_W
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN
- ex_rs1, ex_rs2, ex_rd  out  RA_W
- ex_funct  out  4
- stall_o  out  1  to PC and IF/ID write-enable (active = hold)
- bubble_cnt  out  CNT_W  bubbles inserted since reset

Behaviour:
- Reset (async, immediate):
  - All ex_* outputs are 0, including ex_valid and ex_ctrl.
  - pending_flush = 0.
  - bubble_cnt = 0.
- Per-clock priority:
  1. mem_busy=1: hold every register. If ex_flush=1, set pending_flush.
  2. flush_eff = ex_flush | pending_flush: load a bubble (ex_valid=0, ex_ctrl=0, other fields don't-care but cleared to 0). Clear pending_flush. Counter unchanged.
  3. Load-use hazard: load a bubble and increment bubble_cnt (saturates at all-ones).
  4. Otherwise: load all id_* fields. ex_valid = id_valid. ex_ctrl = id_ctrl if id_valid, else 0.
- Load-use hazard (combinational), asserted when all of the following hold:
  - ex_valid & ex_ctrl[5] (MemRead)
  - ex_rd != 0
  - id_valid
  - (id_rs1 == ex_rd), or (id_rs2 == ex_rd & rs2_used), where rs2_used = ~id_ctrl[2] | id_ctrl[6]
- stall_o = mem_busy | (hazard & ~flush_eff). It is purely combinational: 0-cycle latency from inputs and registered state.
  - During a flush, stall_o is 0 so IF proceeds to the branch target.
- Latency: one cycle from ID to EX when no stall.
- A load-use stall lasts exactly one cycle. After the bubble, ex_ctrl[5]=0, so the hazard self-clears.
- ex_flush and a hazard in the same cycle: the flush wins. No count, no stall.
- pending_flush set and ex_flush also high on the release cycle: a single bubble, no double flush.
- Reset asserted mid-stall or mid-busy: all state clears on the reset edge. The first cycle after deassertion behaves as normal.
- x0 as a destination never creates a hazard.

Decomposition:
- Package rv_ctrl_pkg holds:
  - CTRL_W
  - bit-index constants CTRL_IMMSEL_LO/HI, CTRL_ALUSRC, CTRL_MEM2REG, CTRL_REGWR, CTRL_MEMRD, CTRL_MEMWR, CTRL_BRANCH, CTRL_ALUOP_LO/HI
  - opcode constants OP_R=7'h33, OP_I=7'h13, OP_LOAD=7'h03, OP_STORE=7'h23, OP_BRANCH=7'h63
- One natural sub-module: load_use_detect (purely combinational hazard compare), instantiated inside id_ex_stage.

Test Plan:
1. Reset mid-operation: reset=1 while ex_valid=1 and ex_ctrl=11'h03d → all ex_* outputs 0, bubble_cnt=0, stall_o=0 (mem_busy=0).
2. Normal flow: add x3,x1,x2 (ctrl 11'h210, rs1=1, rs2=2, rd=3) → next cycle ex_ctrl=11'h210, ex_rd=3, ex_valid=1, stall_o=0.
3. Load-use hazard: lw x5 (11'h03d, rd=5) then add rs1=5 → stall_o=1 for one cycle, a bubble (ex_ctrl=0), bubble_cnt=1. The add reaches EX one cycle later.
4. No false hazard:
   - lw x5 then addi with rs2 field=5 (11'h214, AluSrc=1) → no stall.
   - lw x0 then use of rs1=0 → no stall.
   - sw with rs2=5 (11'h045) → stall.
5. Flush vs hazard: the hazard condition and ex_flush=1 in the same cycle → stall_o=0, bubble loaded, bubble_cnt unchanged.
6. Flush during busy: mem_busy=1 for 3 cycles with an ex_flush pulse in cycle 1 → outputs held for 3 cycles. On the first non-busy edge a bubble is loaded and pending_flush clears. Separately, force bubble_cnt to all-ones → it saturates at 16'hFFFF.
